// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with level tracking, almost-full/empty thresholds, registered read data and sticky error flags.
// Optional high-water-mark output enabled by defining SYNC_FIFO_PEAK_EN.
module sync_fifo_flags #(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 1024,
  parameter int AF_THRESH = DEPTH - 4,
  parameter int AE_THRESH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [WIDTH-1:0]         d_in,
  input  logic                     w_enb,
  input  logic                     r_enb,
  input  logic                     err_clr,
  output logic [WIDTH-1:0]         d_out,
  output logic                     d_valid,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic                     underflow
`ifdef SYNC_FIFO_PEAK_EN
  ,
  output logic [$clog2(DEPTH):0]   peak_level
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    w_ptr;
  logic [PW-1:0]    r_ptr;
  logic [LW-1:0]    level_nxt;
  logic             wr_ok;
  logic             rd_ok;

  // Flags decode the level register only, so enables never reach outputs combinationally.
  assign full         = (level == LW'(DEPTH));
  assign empty        = (level == '0);
  assign almost_full  = (level >= LW'(AF_THRESH));
  assign almost_empty = (level <= LW'(AE_THRESH));

  assign wr_ok = w_enb & ~full;
  assign rd_ok = r_enb & ~empty;

  always_comb begin
    level_nxt = level;
    if (wr_ok && !rd_ok)
      level_nxt = level + LW'(1);
    else if (rd_ok && !wr_ok)
      level_nxt = level - LW'(1);
  end

  // Storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr_ok)
      mem[w_ptr] <= d_in;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      w_ptr     <= '0;
      r_ptr     <= '0;
      level     <= '0;
      d_out     <= '0;
      d_valid   <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      level   <= level_nxt;
      d_valid <= rd_ok;
      if (wr_ok)
        w_ptr <= w_ptr + PW'(1);
      if (rd_ok) begin
        r_ptr <= r_ptr + PW'(1);
        d_out <= mem[r_ptr];
      end
      // A new error in the same cycle as err_clr takes priority over the clear.
      overflow  <= (overflow  & ~err_clr) | (w_enb & full);
      underflow <= (underflow & ~err_clr) | (r_enb & empty);
    end
  end

`ifdef SYNC_FIFO_PEAK_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      peak_level <= '0;
    else if (err_clr || (level_nxt > peak_level))
      peak_level <= level_nxt;
  end
`endif

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Directed self-checking bench for sync_fifo_flags (WIDTH=8, DEPTH=8, AF=6, AE=2).
// Covers peak_level as well when SYNC_FIFO_PEAK_EN is defined.
module tb_sync_fifo_flags;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] d_in;
  logic       w_enb;
  logic       r_enb;
  logic       err_clr;
  logic [7:0] d_out;
  logic       d_valid;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       almost_empty;
  logic [3:0] level;
  logic       overflow;
  logic       underflow;
`ifdef SYNC_FIFO_PEAK_EN
  logic [3:0] peak_level;
`endif

  int unsigned total = 0;
  int unsigned bad   = 0;

  sync_fifo_flags #(
    .WIDTH(8),
    .DEPTH(8),
    .AF_THRESH(6),
    .AE_THRESH(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .d_in(d_in),
    .w_enb(w_enb),
    .r_enb(r_enb),
    .err_clr(err_clr),
    .d_out(d_out),
    .d_valid(d_valid),
    .full(full),
    .empty(empty),
    .almost_full(almost_full),
    .almost_empty(almost_empty),
    .level(level),
    .overflow(overflow),
    .underflow(underflow)
`ifdef SYNC_FIFO_PEAK_EN
    ,
    .peak_level(peak_level)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want test done");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample 1ns after the rising edge.
  task automatic cyc(input logic w, input logic r, input logic [7:0] d, input logic clr);
    w_enb = w; r_enb = r; d_in = d; err_clr = clr;
    @(posedge clk);
    #1;
    w_enb = 1'b0; r_enb = 1'b0; err_clr = 1'b0;
  endtask

  initial begin
    reset = 1'b0; w_enb = 1'b0; r_enb = 1'b0; d_in = '0; err_clr = 1'b0;
    #1;
    check("rst_level", level, 0);
    check("rst_empty", empty, 1);
    check("rst_ae", almost_empty, 1);
    check("rst_full", full, 0);
    check("rst_af", almost_full, 0);
    check("rst_dvalid", d_valid, 0);
    check("rst_dout", d_out, 0);
    check("rst_ovf", overflow, 0);
    check("rst_udf", underflow, 0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;

    // 1. Fill
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 1'b0, 8'h10 + 8'(i), 1'b0);
      check("fill_level", level, i + 1);
      check("fill_ae", almost_empty, (i + 1) <= 2);
      check("fill_af", almost_full, (i + 1) >= 6);
      check("fill_full", full, (i + 1) == 8);
    end
    cyc(1'b1, 1'b0, 8'hEE, 1'b0);
    check("fill9_ovf", overflow, 1);
    check("fill9_level", level, 8);

    // 2. Drain
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, 1'b1, 8'h00, 1'b0);
      check("drain_dvalid", d_valid, 1);
      check("drain_dout", d_out, 32'h10 + i);
      check("drain_level", level, 7 - i);
    end
    check("drain_empty", empty, 1);
    cyc(1'b0, 1'b1, 8'h00, 1'b0);
    check("drain9_udf", underflow, 1);
    check("drain9_dout", d_out, 32'h17);
    check("drain9_dvalid", d_valid, 0);
    check("drain9_ovf_sticky", overflow, 1);

    // 5a. err_clr with no error condition
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    check("clr_ovf", overflow, 0);
    check("clr_udf", underflow, 0);

    // 3. Wrap and simultaneous access
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 8'h20 + 8'(i), 1'b0);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 1'b1, 8'h00, 1'b0);
      check("wrap_rd", d_out, 32'h20 + i);
    end
    cyc(1'b1, 1'b1, 8'h30, 1'b0);
    check("sim0_level", level, 1);
    check("sim0_dvalid", d_valid, 0);
    check("sim0_udf", underflow, 1);
    for (int k = 1; k < 10; k++) begin
      cyc(1'b1, 1'b1, 8'h30 + 8'(k), 1'b0);
      check("sim_level", level, 1);
      check("sim_dvalid", d_valid, 1);
      check("sim_dout", d_out, 32'h30 + k - 1);
    end
    cyc(1'b0, 1'b0, 8'h00, 1'b1);

    // 4. Boundary simultaneous cases
    cyc(1'b0, 1'b1, 8'h00, 1'b0);
    check("b_last", d_out, 32'h39);
    check("b_empty", empty, 1);
    cyc(1'b1, 1'b1, 8'h40, 1'b0);
    check("be_level", level, 1);
    check("be_udf", underflow, 1);
    check("be_dvalid", d_valid, 0);
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    for (int i = 1; i < 8; i++) cyc(1'b1, 1'b0, 8'h40 + 8'(i), 1'b0);
    check("bf_full", full, 1);
    cyc(1'b1, 1'b1, 8'h50, 1'b0);
    check("bf_level", level, 7);
    check("bf_ovf", overflow, 1);
    check("bf_dvalid", d_valid, 1);
    check("bf_dout", d_out, 32'h40);

    // 5b. err_clr concurrent with a write to a full FIFO
    cyc(1'b1, 1'b0, 8'h48, 1'b0);
    check("c_full", full, 1);
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    check("c_ovf_cleared", overflow, 0);
    cyc(1'b1, 1'b0, 8'h51, 1'b1);
    check("c_ovf_wins", overflow, 1);
    check("c_level", level, 8);
    check("c_udf", underflow, 0);

    // 6. Async reset mid-stream at level 5
    cyc(1'b0, 1'b1, 8'h00, 1'b0);
    cyc(1'b0, 1'b1, 8'h00, 1'b0);
    cyc(1'b0, 1'b1, 8'h00, 1'b1);
    check("r_level5", level, 5);
    check("r_dvalid_pre", d_valid, 1);
    check("r_dout_pre", d_out, 32'h43);
`ifdef SYNC_FIFO_PEAK_EN
    check("r_peak_pre", peak_level, 5);
`endif
    #3;
    reset = 1'b0;
    #1;
    check("r_level0", level, 0);
    check("r_empty", empty, 1);
    check("r_dvalid", d_valid, 0);
`ifdef SYNC_FIFO_PEAK_EN
    check("r_peak_post", peak_level, 0);
`endif
    @(posedge clk); #1;
    reset = 1'b1;
    cyc(1'b1, 1'b0, 8'hAA, 1'b0);
    check("r_wr_level", level, 1);
    cyc(1'b0, 1'b1, 8'h00, 1'b0);
    check("r_rd_dout", d_out, 32'hAA);
    check("r_rd_dvalid", d_valid, 1);
    check("r_rd_empty", empty, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sync_fifo_flags.md
Name: sync_fifo_flags

Overview:
Parametrised single-clock FIFO and next-generation buffer for the datapath. Adds the following over a plain full/empty FIFO:
- correct level tracking on simultaneous read and write
- fill-level output
- programmable almost-full and almost-empty thresholds
- registered read data with a valid strobe
- sticky overflow and underflow error flags

Sits between a producer and a consumer in the same clock domain.

Parameters:
WIDTH, 32, data word width in bits (>=1)
DEPTH, 1024, number of entries; power of two, >=4
AF_THRESH, DEPTH-4, almost_full asserts when level >= AF_THRESH (1..DEPTH)
AE_THRESH, 4, almost_empty asserts when level <= AE_THRESH (0..DEPTH-1)

Ports:
clk  in  1  clock, all logic rising-edge
reset  in  1  asynchronous, active-low reset
d_in  in  WIDTH  write data
w_enb  in  1  write request
r_enb  in  1  read request
err_clr  in  1  clears overflow/underflow (and peak_level when enabled)
d_out  out  WIDTH  registered read data
d_valid  out  1  d_out updated this cycle (1-cycle pulse per accepted read)
full  out  1  level == DEPTH
empty  out  1  level == 0
almost_full  out  1  level >= AF_THRESH
almost_empty  out  1  level <= AE_THRESH
level  out  $clog2(DEPTH)+1  current occupancy
overflow  out  1  sticky: write attempted while full
underflow  out  1  sticky: read attempted while empty

Behaviour:
- Reset (reset=0, async assert, sync-released by the system):
  - w_ptr, r_ptr, level = 0
  - d_out = 0, d_valid = 0, overflow = 0, underflow = 0
  - Therefore empty=1, almost_empty=1, full=0, almost_full=0
  - Storage array is not reset.
- Write acceptance: wr_ok = w_enb & ~full, evaluated on current-cycle full.
  - On wr_ok: mem[w_ptr] <= d_in; w_ptr increments, wrapping DEPTH-1 -> 0.
- Read acceptance: rd_ok = r_enb & ~empty, evaluated on current-cycle empty.
  - On rd_ok: d_out <= mem[r_ptr] next edge; d_valid=1 that cycle; r_ptr increments with wrap.
  - Read latency is 1 cycle. d_out holds its last value when no read is accepted; d_valid=0 otherwise.
- Level update per edge:
  - +1 if wr_ok & ~rd_ok
  - -1 if rd_ok & ~wr_ok
  - unchanged if both or neither
- Full FIFO with w_enb and r_enb both high: the read is accepted, the write is rejected, level becomes DEPTH-1, overflow is set.
- Empty FIFO with both high: the write is accepted, the read is rejected (no fall-through), level becomes 1, underflow is set.
- Flags full, empty, almost_full and almost_empty are combinational decodes of the level register only. No combinational path from w_enb/r_enb to any output.
- Sticky errors:
  - overflow set on w_enb & full; underflow set on r_enb & empty.
  - err_clr clears them on the next edge. A set in the same cycle as err_clr wins.
- Pointers are $clog2(DEPTH) bits; wrap is natural binary rollover.
- A reset mid-operation discards all contents immediately; there is no partial state afterwards.

Optional Feature:
Macro SYNC_FIFO_PEAK_EN.
- Defined: adds output port peak_level (width $clog2(DEPTH)+1).
  - peak_level is a high-water mark: on each edge it is loaded with max(peak_level, next level).
  - It resets to 0. err_clr reloads it with the current level, or with the next level when both change.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
All scenarios use WIDTH=8, DEPTH=8, AF_THRESH=6, AE_THRESH=2.
1. Fill: write 0x10..0x17 on 8 consecutive cycles.
   - level steps 1..8; almost_empty drops when level=3; almost_full rises when level=6; full=1 at 8.
   - A 9th write sets overflow=1, level stays 8.
2. Drain: read 8 times back-to-back.
   - d_out = 0x10..0x17, each one cycle after its accepted read, d_valid high 8 cycles; empty=1 at end.
   - A 9th read sets underflow=1, d_out holds 0x17, d_valid=0.
3. Wrap plus simultaneous access:
   - Write 5, read 5, then drive w_enb=r_enb=1 for 10 cycles with incrementing data.
   - level stays constant; data order is preserved across pointer wrap.
4. Boundary simultaneous cases:
   - Full FIFO with both enables: level 8->7, overflow=1, oldest word read.
   - Empty FIFO with both enables: level 0->1, underflow=1, d_valid=0.
5. Error clear:
   - Pulse err_clr with no error condition: overflow=underflow=0 next cycle.
   - Pulse err_clr together with a write to a full FIFO: overflow stays 1.
6. Async reset mid-stream with level=5:
   - Assert reset between clock edges: level=0, empty=1, d_valid=0 immediately.
   - After release, a write of 0xAA then a read returns 0xAA.
   - With SYNC_FIFO_PEAK_EN defined: peak_level=5 before the reset, 0 after it.
